// File: rtl/xyt_pkg.sv
// Shared types and constants for the x/y/t event detector.
// Holds the FSM state encoding, datapath widths and threshold defaults.
package xyt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    ACTIVE  = 2'd2,
    HOLDOFF = 2'd3
  } state_e;

  localparam int unsigned MAG_W = 4;
  localparam int unsigned CNT_W = 8;

  localparam logic HI_SEL = 1'b0;
  localparam logic LO_SEL = 1'b1;

  localparam logic [MAG_W-1:0] HI_TH_DEF = 4'd6;
  localparam logic [MAG_W-1:0] LO_TH_DEF = 4'd3;

  // Zero-extended sum of the three 2-bit window sums (0..9).
  function automatic logic [MAG_W-1:0] mag_sum(input logic [1:0] a,
                                               input logic [1:0] b,
                                               input logic [1:0] c);
    return MAG_W'(a) + MAG_W'(b) + MAG_W'(c);
  endfunction

endpackage

// File: rtl/xyt_sat_counter.sv
// Saturating up-counter with synchronous clear; clear plus increment yields 1.
module xyt_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = inc_i ? W'(1) : '0;
    else if (inc_i && (cnt_q != {W{1'b1}}))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/xyt_event_detector.sv
// Hysteresis / confirm / holdoff event detector over m = x + y + t.
// Emits a one-cycle trigger pulse, an active level and a saturating count.
module xyt_event_detector
  import xyt_pkg::*;
#(
  parameter int unsigned CONFIRM        = 2,
  parameter int unsigned HOLDOFF_CYCLES = 8,
  parameter int unsigned HI_TH_DEFAULT  = 6,
  parameter int unsigned LO_TH_DEFAULT  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       x_avg,
  input  logic [1:0]       y_avg,
  input  logic [1:0]       t_avg,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [3:0]       cfg_data,
  input  logic             clr_count,
  output logic             event_pulse,
  output logic             active,
  output logic [CNT_W-1:0] event_count,
  output logic [1:0]       state_o,
  output logic [MAG_W-1:0] mag_o
);

  state_e           state_q;
  logic [1:0]       confirm_q;
  logic [7:0]       holdoff_q;
  logic [MAG_W-1:0] hi_q, lo_q, mag_q, mag_d;
  logic             pulse_q, active_q;
  logic             trig;

  assign mag_d = mag_sum(x_avg, y_avg, t_avg);

  // Confirming sample: this one completes the run of qualifying samples.
  assign trig = (state_q == ARMED) && in_valid && (mag_d >= hi_q) &&
                ((confirm_q + 2'd1) == 2'(CONFIRM));

  // rst_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= IDLE;
      confirm_q <= '0;
      holdoff_q <= '0;
      hi_q      <= MAG_W'(HI_TH_DEFAULT);
      lo_q      <= MAG_W'(LO_TH_DEFAULT);
      mag_q     <= '0;
      pulse_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      pulse_q <= trig;
      if (in_valid) mag_q <= mag_d;
      // Thresholds update next edge; this cycle's sample sees the old value.
      if (cfg_we) begin
        if (cfg_sel == HI_SEL) hi_q <= cfg_data;
        else                   lo_q <= cfg_data;
      end
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q   <= ARMED;
            confirm_q <= '0;
          end
        end
        ARMED: begin
          if (in_valid) begin
            if (trig) begin
              state_q   <= ACTIVE;
              active_q  <= 1'b1;
              confirm_q <= '0;
            end else if (mag_d >= hi_q) begin
              confirm_q <= confirm_q + 2'd1;
            end else begin
              confirm_q <= '0;
            end
          end
        end
        ACTIVE: begin
          if (in_valid && (mag_d <= lo_q)) begin
            state_q   <= HOLDOFF;
            active_q  <= 1'b0;
            holdoff_q <= 8'(HOLDOFF_CYCLES);
          end
        end
        HOLDOFF: begin
          holdoff_q <= holdoff_q - 8'd1;
          if (holdoff_q == 8'd1) begin
            state_q   <= ARMED;
            confirm_q <= '0;
          end
        end
      endcase
    end
  end

  xyt_sat_counter #(.W(CNT_W)) u_cnt (
    .clk_i (clk),
    .rst_i (rst_n),
    .clr_i (clr_count),
    .inc_i (trig),
    .cnt_o (event_count)
  );

  assign event_pulse = pulse_q;
  assign active      = active_q;
  assign state_o     = state_q;
  assign mag_o       = mag_q;

endmodule
